call_stack: RTL and testbench
=============================

// Module: call_stack
// PURPOSE
// - Parametrised return-address stack for the multicycle processor. It replaces the fixed single-purpose stack.
// - PC is pushed on a call and popped into the PC mux on a return.
// - Adds: configurable width/depth, a selectable full-push policy (saturate or circular overwrite),
//   simultaneous push+pop (replace top), an occupancy count, sticky error flags and a synchronous clear.
// - Single clock domain. It does not use the split wclk/rclk of the previous stack.
// PARAMETERS
// - WIDTH     32  bits per entry (PC width)
// - DEPTH     8   number of entries; >=2, need not be a power of two
// - OVF_MODE  0   full-push policy: 0 = saturate (push dropped), 1 = wrap (overwrite oldest entry)
// PORTS
// - clk      in   1                 single system clock, rising-edge
// - rst_n    in   1                 asynchronous, active-low reset
// - push     in   1                 push dado this cycle
// - pop      in   1                 pop top-of-stack this cycle
// - clear    in   1                 synchronous flush: empties the stack and clears the flags
// - dado     in   WIDTH             data to push
// - saida    out  WIDTH             current top-of-stack; 0 when empty
// - count    out  $clog2(DEPTH+1)   number of valid entries
// - empty    out  1                 count==0
// - full     out  1                 count==DEPTH
// - ovrflw   out  1                 sticky: a push occurred while full
// - undrflw  out  1                 sticky: a pop occurred while empty
// BEHAVIOUR
// - Reset (rst_n=0, async): top pointer=0, count=0, ovrflw=0, undrflw=0.
//   So saida=0, empty=1, full=0. Storage array is not reset.
// - saida is a combinational read of mem[top], forced to 0 when empty.
//   The value is valid in the same cycle pop is asserted. The pointer moves at the next rising edge.
// - Priority per edge: clear > push/pop. On clear, count=0 and flags=0; push/pop are ignored that cycle.
// - Push only, not full: top=(top+1) mod DEPTH, mem[new top]=dado, count+1.
// - Push only, full, OVF_MODE=0: no state change; ovrflw<=1.
// - Push only, full, OVF_MODE=1: top advances with wrap; the oldest entry is overwritten.
//   count stays DEPTH; ovrflw<=1.
// - Pop only, not empty: top=(top-1) mod DEPTH, count-1.
// - Pop only, empty: no state change; undrflw<=1.
// - Push+pop, not empty: mem[top]=dado. Pointer and count unchanged; saida shows the old top this cycle.
//   No flag is set, even when full.
// - Push+pop, empty: behaves as push alone; undrflw<=1.
// - Pointer arithmetic is explicitly modulo DEPTH (compare-and-wrap, not bit truncation).
// - Flags stay high until clear or reset.
// - Latency: a push becomes visible on saida the cycle after the edge. Pop result is combinational (0 cycles).
// - Reset asserted mid-operation discards the contents. The first pop after reset flags undrflw.
// STRUCTURE
// - Package call_stack_pkg holds:
//   - localparams OVF_SATURATE=0 and OVF_WRAP=1
//   - a function cs_inc(ptr,DEPTH) and a function cs_dec(ptr,DEPTH) for modulo-DEPTH wrap
// - Sub-module call_stack_mem: DEPTH x WIDTH register array, one synchronous write port,
//   one asynchronous read port.
// - The top level holds the pointer, count, flags and all control decode.
// TESTING (WIDTH=32, DEPTH=4 unless stated)
// 1. Push 3 values, then drop rst_n for 1 ns mid-cycle.
//    -> count=0, empty=1, saida=0, ovrflw=undrflw=0 immediately, without waiting for an edge.
// 2. Push 0x10, 0x11, 0x12, then pop 3 cycles.
//    -> saida=0x12, 0x11, 0x10 in the pop cycles; then empty=1, saida=0.
// 3. OVF_MODE=0: push 1..5.
//    -> count=4, full=1, ovrflw=1, saida=4; four pops return 4, 3, 2, 1.
// 4. OVF_MODE=1: push 1..5.
//    -> count=4, ovrflw=1, saida=5; four pops return 5, 4, 3, 2; then empty=1.
// 5. Stack {0x10, 0x20} (top 0x20); push+pop with dado=0x30.
//    -> saida=0x20 that cycle; next cycle saida=0x30, count=2, no flags set.
// 6. Pop when empty -> undrflw=1. Push 0x7 -> undrflw stays 1.
//    Then clear together with push 0x8 -> count=0, undrflw=0, push ignored.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack.
// Full-push policy codes and modulo-depth pointer helpers.
package call_stack_pkg;

  localparam int OVF_SATURATE = 0;
  localparam int OVF_WRAP     = 1;

  // Compare-and-wrap so that non power-of-two depths work.
  function automatic int cs_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int cs_dec(input int ptr, input int depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x WIDTH register array for the call stack.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module call_stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Parametrised return-address stack: push/pop/replace, clear, sticky flags.
// Ports: clk, rst_n, push, pop, clear, dado -> saida, count, empty, full, ovrflw, undrflw.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = OVF_SATURATE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           dado,
  output logic [WIDTH-1:0]           saida,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovrflw,
  output logic                       undrflw
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    topQ, topD, topInc, topDec, wrAddr;
  logic [CW-1:0]    cntQ, cntD;
  logic             ovfQ, ovfD, unfQ, unfD;
  logic             wrEn, isEmpty, isFull;
  logic             opRep, opPush, opPop;
  logic [WIDTH-1:0] rdData;

  assign topInc = PW'(cs_inc(int'(topQ), DEPTH));
  assign topDec = PW'(cs_dec(int'(topQ), DEPTH));

  assign isEmpty = (cntQ == '0);
  assign isFull  = (cntQ == CW'(DEPTH));

  // Mutually exclusive operation decode; clear wins.
  // Push+pop on an empty stack falls into opPush.
  assign opRep  = !clear && push && pop && !isEmpty;
  assign opPush = !clear && push && !(pop && !isEmpty);
  assign opPop  = !clear && pop && !push;

  always_comb begin
    topD   = topQ;
    cntD   = cntQ;
    ovfD   = ovfQ;
    unfD   = unfQ;
    wrEn   = 1'b0;
    wrAddr = topQ;
    unique case (1'b1)
      clear: begin
        topD = '0;
        cntD = '0;
        ovfD = 1'b0;
        unfD = 1'b0;
      end
      opRep: begin
        wrEn   = 1'b1;
        wrAddr = topQ;
      end
      opPush: begin
        if (pop) unfD = 1'b1;
        if (!isFull) begin
          topD   = topInc;
          cntD   = cntQ + CW'(1);
          wrEn   = 1'b1;
          wrAddr = topInc;
        end else begin
          ovfD = 1'b1;
          if (OVF_MODE == OVF_WRAP) begin
            topD   = topInc;
            wrEn   = 1'b1;
            wrAddr = topInc;
          end
        end
      end
      opPop: begin
        if (isEmpty) begin
          unfD = 1'b1;
        end else begin
          topD = topDec;
          cntD = cntQ - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      topQ <= '0;
      cntQ <= '0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      topQ <= topD;
      cntQ <= cntD;
      ovfQ <= ovfD;
      unfQ <= unfD;
    end
  end

  call_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) uMem (
    .clk  (clk),
    .we   (wrEn),
    .waddr(wrAddr),
    .wdata(dado),
    .raddr(topQ),
    .rdata(rdData)
  );

  assign saida   = isEmpty ? '0 : rdData;
  assign count   = cntQ;
  assign empty   = isEmpty;
  assign full    = isFull;
  assign ovrflw  = ovfQ;
  assign undrflw = unfQ;

endmodule

// File: tb/tb_call_stack.sv
// Testbench for call_stack: saturate and wrap instances, DEPTH=4.
// Vector table with scoreboard queue plus hand-written corner sequences.
`timescale 1ns/100ps
module tb_call_stack;

  localparam int W = 32;
  localparam int D = 4;

  typedef logic [38:0] obs_t;

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [31:0] d;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic clear = 1'b0;
  logic [W-1:0] dado = '0;

  logic [W-1:0] s0, s1;
  logic [2:0]   c0, c1;
  logic e0, f0, o0, u0, e1, f1, o1, u1;

  int nAssert = 0;
  int nFail = 0;

  vec_t vecs[$];
  obs_t expQ[$];

  always #5 clk = ~clk;

  call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(0)) dutSat (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .clear(clear), .dado(dado), .saida(s0), .count(c0),
    .empty(e0), .full(f0), .ovrflw(o0), .undrflw(u0)
  );

  call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(1)) dutWrap (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .clear(clear), .dado(dado), .saida(s1), .count(c1),
    .empty(e1), .full(f1), .ovrflw(o1), .undrflw(u1)
  );

  function automatic obs_t mkObs(input logic [31:0] s, input int c,
                                 input logic o, input logic u);
    return {s, 3'(c), (c == 0), (c == D), o, u};
  endfunction

  function automatic vec_t mk(input logic p, input logic q, input logic cl,
                              input logic [31:0] d, input logic [31:0] s,
                              input int c, input logic o, input logic u);
    vec_t v;
    v.push = p;
    v.pop = q;
    v.clr = cl;
    v.d = d;
    v.exp = mkObs(s, c, o, u);
    return v;
  endfunction

  function automatic obs_t got0();
    return {s0, c0, e0, f0, o0, u0};
  endfunction

  function automatic obs_t got1();
    return {s1, c1, e1, f1, o1, u1};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got saida=%h cnt=%0d e/f/o/u=%b want saida=%h cnt=%0d e/f/o/u=%b",
               name, act[38:7], act[6:4], act[3:0],
               exp[38:7], exp[6:4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic cl,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    push = p;
    pop = q;
    clear = cl;
    dado = d;
  endtask

  initial begin
    // 1: async reset mid-operation
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", got0(), mkObs(0, 0, 0, 0));
    drive(1, 0, 0, 32'hA1);
    drive(1, 0, 0, 32'hA2);
    drive(1, 0, 0, 32'hA3);
    drive(0, 0, 0, 32'h0);
    @(negedge clk);
    check("pre_reset", got0(), mkObs(32'hA3, 3, 0, 0));
    #1 rst_n = 1'b0;
    #0.5;
    check("async_reset", got0(), mkObs(0, 0, 0, 0));
    check("async_reset_w", got1(), mkObs(0, 0, 0, 0));
    #0.5 rst_n = 1'b1;

    // 2: LIFO order
    vecs.push_back(mk(1, 0, 0, 'h10, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 'h11, 'h10, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 'h12, 'h11, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h12, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h11, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h10, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // 3: saturate on full
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 2, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4, 3, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5, 4, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
    // 5: replace top
    vecs.push_back(mk(1, 0, 0, 'h10, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 'h20, 'h10, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 'h30, 'h20, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h30, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 'h30, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h10, 1, 0, 0));
    // 6: underflow, then clear beats push
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 7, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 8, 7, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // push+pop on empty acts as push and flags underflow
    vecs.push_back(mk(1, 1, 0, 9, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 9, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 9, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].d);
      expQ.push_back(vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d", i), got0(), expQ.pop_front());
    end

    // 4: wrap mode overwrites oldest
    for (int k = 1; k <= 5; k++) drive(1, 0, 0, 32'(k));
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("wrap_full", got1(), mkObs(5, 4, 1, 0));
    check("sat_full", got0(), mkObs(4, 4, 1, 0));
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0);
      @(negedge clk);
      check($sformatf("wrap_pop%0d", k), got1(), mkObs(32'(5 - k), 4 - k, 1, 0));
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("wrap_empty", got1(), mkObs(0, 0, 1, 0));

    // replace on a full stack sets no flag
    drive(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) drive(1, 0, 0, 32'(k));
    drive(1, 1, 0, 32'hEE);
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("full_replace", got0(), mkObs(32'hEE, 4, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
